// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
//
// ID -> EX pipeline register with a single skid buffer. The main register
// drives every out_* port directly. The skid register catches one payload
// when EX stalls. in_ready is therefore a pure register output, so the ID
// stage never sees a combinational path from out_ready.
//
// Parameters
//   DATA_WIDTH      operand / immediate width
//   ADDR_WIDTH      PC width
//   NUM_SRC         number of source-operand channels (1..4)
//   REG_ADDR_WIDTH  destination register index width
//   CTRL_WIDTH      opaque control bundle width
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid        ID payload valid
//   in_ready        stage can accept (equals !skid_valid)
//   flush           drop every held entry on the next edge
//   in_pc, in_rs_data, in_imm, in_rd, in_ctrl     ID payload
//   out_valid       EX payload valid
//   out_ready       EX accepts
//   out_pc, out_rs_data, out_imm, out_rd, out_ctrl  EX payload (registered)
//   stall_cnt       [ID_EX_STALL_CNT_EN only] cycles with out_valid && !out_ready
//   bubble_cnt      [ID_EX_STALL_CNT_EN only] cycles with !out_valid && out_ready
//
// Optional feature macro: ID_EX_STALL_CNT_EN
//
// State table
//   state | meaning
//   EMPTY | neither main nor skid holds a payload
//   ONE   | main holds a payload, skid empty
//   TWO   | main and skid both hold payloads; in_ready = 0
// -----------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SRC        = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,

    input  logic [ADDR_WIDTH-1:0]         in_pc,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] in_rs_data,
    input  logic [DATA_WIDTH-1:0]         in_imm,
    input  logic [REG_ADDR_WIDTH-1:0]     in_rd,
    input  logic [CTRL_WIDTH-1:0]         in_ctrl,

    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH-1:0]         out_pc,
    output logic [NUM_SRC*DATA_WIDTH-1:0] out_rs_data,
    output logic [DATA_WIDTH-1:0]         out_imm,
    output logic [REG_ADDR_WIDTH-1:0]     out_rd,
    output logic [CTRL_WIDTH-1:0]         out_ctrl
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;

    logic                          main_valid;
    logic                          skid_valid;

    logic [ADDR_WIDTH-1:0]         skid_pc;
    logic [NUM_SRC*DATA_WIDTH-1:0] skid_rs_data;
    logic [DATA_WIDTH-1:0]         skid_imm;
    logic [REG_ADDR_WIDTH-1:0]     skid_rd;
    logic [CTRL_WIDTH-1:0]         skid_ctrl;

    logic in_xfer;
    logic out_xfer;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;

    // rst is handled first in the sequential block, so it needs no term here.
    assign in_xfer  = in_valid && in_ready && !flush;
    assign out_xfer = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            main_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            out_pc       <= '0;
            out_rs_data  <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_ctrl     <= '0;
            skid_pc      <= '0;
            skid_rs_data <= '0;
            skid_imm     <= '0;
            skid_rd      <= '0;
            skid_ctrl    <= '0;
        end else if (flush) begin
            // Payload registers keep stale data; only the valids matter.
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        out_pc      <= in_pc;
                        out_rs_data <= in_rs_data;
                        out_imm     <= in_imm;
                        out_rd      <= in_rd;
                        out_ctrl    <= in_ctrl;
                        main_valid  <= 1'b1;
                        state       <= ONE;
                    end
                end

                ONE: begin
                    if (in_xfer && out_xfer) begin
                        // Main drains and refills in the same cycle.
                        out_pc      <= in_pc;
                        out_rs_data <= in_rs_data;
                        out_imm     <= in_imm;
                        out_rd      <= in_rd;
                        out_ctrl    <= in_ctrl;
                    end else if (in_xfer) begin
                        // Main is stalled (out_valid=1, out_ready=0): park in skid.
                        skid_pc      <= in_pc;
                        skid_rs_data <= in_rs_data;
                        skid_imm     <= in_imm;
                        skid_rd      <= in_rd;
                        skid_ctrl    <= in_ctrl;
                        skid_valid   <= 1'b1;
                        state        <= TWO;
                    end else if (out_xfer) begin
                        main_valid <= 1'b0;
                        state      <= EMPTY;
                    end
                end

                TWO: begin
                    if (out_xfer) begin
                        out_pc      <= skid_pc;
                        out_rs_data <= skid_rs_data;
                        out_imm     <= skid_imm;
                        out_rd      <= skid_rd;
                        out_ctrl    <= skid_ctrl;
                        skid_valid  <= 1'b0;
                        state       <= ONE;
                    end
                end

                default: begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Free-running wrap-around counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_valid && !out_ready)
                stall_cnt <= stall_cnt + 32'd1;
            if (!main_valid && out_ready)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe
//
// Directed bench for id_ex_pipe. Instance u_dut_a uses default parameters;
// instance u_dut_b uses NUM_SRC=3, DATA_WIDTH=64 to exercise channel order
// and, when ID_EX_STALL_CNT_EN is defined, the stall/bubble counters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_ex_pipe;

    localparam int A_DW  = 32;
    localparam int A_AW  = 32;
    localparam int A_NS  = 2;
    localparam int B_DW  = 64;
    localparam int B_NS  = 3;
    localparam int RAW   = 5;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic                  a_in_valid, a_in_ready, a_flush;
    logic [A_AW-1:0]       a_in_pc, a_out_pc;
    logic [A_NS*A_DW-1:0]  a_in_rs, a_out_rs;
    logic [A_DW-1:0]       a_in_imm, a_out_imm;
    logic [RAW-1:0]        a_in_rd, a_out_rd;
    logic [CW-1:0]         a_in_ctrl, a_out_ctrl;
    logic                  a_out_valid, a_out_ready;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]           a_stall_cnt, a_bubble_cnt;
`endif

    id_ex_pipe #(
        .DATA_WIDTH(A_DW), .ADDR_WIDTH(A_AW), .NUM_SRC(A_NS),
        .REG_ADDR_WIDTH(RAW), .CTRL_WIDTH(CW)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
        .in_pc(a_in_pc), .in_rs_data(a_in_rs), .in_imm(a_in_imm),
        .in_rd(a_in_rd), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pc(a_out_pc), .out_rs_data(a_out_rs), .out_imm(a_out_imm),
        .out_rd(a_out_rd), .out_ctrl(a_out_ctrl)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
`endif
    );

    // ---------------- instance B ----------------
    logic                  b_in_valid, b_in_ready, b_flush;
    logic [A_AW-1:0]       b_in_pc, b_out_pc;
    logic [B_NS*B_DW-1:0]  b_in_rs, b_out_rs;
    logic [B_DW-1:0]       b_in_imm, b_out_imm;
    logic [RAW-1:0]        b_in_rd, b_out_rd;
    logic [CW-1:0]         b_in_ctrl, b_out_ctrl;
    logic                  b_out_valid, b_out_ready;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]           b_stall_cnt, b_bubble_cnt;
`endif

    id_ex_pipe #(
        .DATA_WIDTH(B_DW), .ADDR_WIDTH(A_AW), .NUM_SRC(B_NS),
        .REG_ADDR_WIDTH(RAW), .CTRL_WIDTH(CW)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
        .in_pc(b_in_pc), .in_rs_data(b_in_rs), .in_imm(b_in_imm),
        .in_rd(b_in_rd), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_rs_data(b_out_rs), .out_imm(b_out_imm),
        .out_rd(b_out_rd), .out_ctrl(b_out_ctrl)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a payload on instance A; rs ch0 = 0xAAAA0000+pc, ch1 = ~pc.
    task automatic a_drive(input logic valid, input logic [31:0] pc);
        a_in_valid = valid;
        a_in_pc    = pc;
        a_in_rs    = {~pc, 32'hAAAA_0000 + pc};
        a_in_imm   = pc + 32'h1000;
        a_in_rd    = pc[6:2];
        a_in_ctrl  = pc[15:0] ^ 16'h5A5A;
    endtask

    // Full payload check for instance A against a pc-derived expectation.
    task automatic a_expect(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, 256'(a_out_valid), 256'(1'b1));
        check({tag, ".pc"},    256'(a_out_pc),    256'(pc));
        check({tag, ".rs"},    256'(a_out_rs),    256'({~pc, 32'hAAAA_0000 + pc}));
        check({tag, ".imm"},   256'(a_out_imm),   256'(pc + 32'h1000));
        check({tag, ".rd"},    256'(a_out_rd),    256'(pc[6:2]));
        check({tag, ".ctrl"},  256'(a_out_ctrl),  256'(pc[15:0] ^ 16'h5A5A));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_out_ready = 1'b0;
        a_drive(1'b1, 32'h100);
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        b_in_pc = '0; b_in_rs = '0; b_in_imm = '0; b_in_rd = '0; b_in_ctrl = '0;

        // ---- reset with in_valid held ----
        step(); step();
        check("rst.out_valid", 256'(a_out_valid), 256'(1'b0));
        check("rst.out_pc",    256'(a_out_pc),    256'(0));
        check("rst.out_rs",    256'(a_out_rs),    256'(0));
        check("rst.out_ctrl",  256'(a_out_ctrl),  256'(0));
        rst = 1'b0;
        a_drive(1'b0, 32'h0);
        step();
        check("rst.in_ready_after",  256'(a_in_ready),  256'(1'b1));
        check("rst.no_output",       256'(a_out_valid), 256'(1'b0));
`ifdef ID_EX_STALL_CNT_EN
        check("rst.stall_cnt",  256'(a_stall_cnt),  256'(0));
        check("rst.bubble_cnt", 256'(a_bubble_cnt), 256'(0));
`endif

        // ---- streaming with out_ready high ----
        a_out_ready = 1'b1;
        a_drive(1'b1, 32'h0);
        step();
        a_expect("stream0", 32'h0);
        check("stream0.in_ready", 256'(a_in_ready), 256'(1'b1));
        a_drive(1'b1, 32'h4);
        step();
        a_expect("stream1", 32'h4);
        check("stream1.in_ready", 256'(a_in_ready), 256'(1'b1));
        a_drive(1'b1, 32'h8);
        step();
        a_expect("stream2", 32'h8);
        check("stream2.in_ready", 256'(a_in_ready), 256'(1'b1));
        a_drive(1'b0, 32'h0);
        step();
        check("stream.drained", 256'(a_out_valid), 256'(1'b0));

        // ---- backpressure into the skid ----
        a_out_ready = 1'b0;
        a_drive(1'b1, 32'h10);
        step();
        a_expect("bp.first", 32'h10);
        check("bp.one_in_ready", 256'(a_in_ready), 256'(1'b1));
        a_drive(1'b1, 32'h14);
        step();
        a_expect("bp.two_main", 32'h10);
        check("bp.two_in_ready", 256'(a_in_ready), 256'(1'b0));
        step();   // in_valid still high but in_ready low: no transfer
        a_drive(1'b0, 32'h0);
        a_expect("bp.hold", 32'h10);
        check("bp.hold_in_ready", 256'(a_in_ready), 256'(1'b0));
        a_out_ready = 1'b1;
        step();
        a_expect("bp.pop1", 32'h14);
        check("bp.pop1_in_ready", 256'(a_in_ready), 256'(1'b1));
        step();
        check("bp.pop2_empty", 256'(a_out_valid), 256'(1'b0));

        // ---- flush in TWO with a concurrent input ----
        a_out_ready = 1'b0;
        a_drive(1'b1, 32'h30);
        step();
        a_drive(1'b1, 32'h34);
        step();
        check("fl.pre_in_ready", 256'(a_in_ready), 256'(1'b0));
        a_drive(1'b1, 32'h20);
        a_flush = 1'b1;
        step();
        check("fl.out_valid", 256'(a_out_valid), 256'(1'b0));
        check("fl.in_ready",  256'(a_in_ready),  256'(1'b1));
        a_flush = 1'b0;
        a_drive(1'b0, 32'h0);
        a_out_ready = 1'b1;
        step();
        check("fl.no_0x20_a", 256'(a_out_valid), 256'(1'b0));
        step();
        check("fl.no_0x20_b", 256'(a_out_valid), 256'(1'b0));

        // ---- flush and rst together from ONE ----
        a_out_ready = 1'b0;
        a_drive(1'b1, 32'h40);
        step();
        a_expect("fr.one", 32'h40);
        a_drive(1'b1, 32'h44);
        a_flush = 1'b1;
        rst = 1'b1;
        step();
        check("fr.out_valid", 256'(a_out_valid), 256'(1'b0));
        check("fr.out_pc",    256'(a_out_pc),    256'(0));
        check("fr.out_imm",   256'(a_out_imm),   256'(0));
        check("fr.in_ready",  256'(a_in_ready),  256'(1'b1));
`ifdef ID_EX_STALL_CNT_EN
        check("fr.stall_cnt", 256'(a_stall_cnt), 256'(0));
`endif
        rst = 1'b0;
        a_flush = 1'b0;
        a_drive(1'b0, 32'h0);
        step();
        check("fr.post_idle", 256'(a_out_valid), 256'(1'b0));

        // ---- instance B: 3 channels x 64 bits, stall counting ----
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_pc     = 32'h50;
        b_in_rs     = {64'h3, 64'h2, 64'h1};
        b_in_imm    = 64'hDEAD_BEEF_0000_0001;
        b_in_rd     = 5'd7;
        b_in_ctrl   = 16'h1234;
        step();
        b_in_valid = 1'b0;
        check("b.out_valid", 256'(b_out_valid), 256'(1'b1));
        check("b.ch0", 256'(b_out_rs[0*B_DW +: B_DW]), 256'(64'h1));
        check("b.ch1", 256'(b_out_rs[1*B_DW +: B_DW]), 256'(64'h2));
        check("b.ch2", 256'(b_out_rs[2*B_DW +: B_DW]), 256'(64'h3));
        check("b.imm", 256'(b_out_imm), 256'(64'hDEAD_BEEF_0000_0001));
        check("b.rd",  256'(b_out_rd),  256'(5'd7));
        for (int i = 0; i < 5; i++) step();
        check("b.hold_pc", 256'(b_out_pc), 256'(32'h50));
`ifdef ID_EX_STALL_CNT_EN
        check("b.stall_cnt5", 256'(b_stall_cnt),  256'(5));
        check("b.bubble0",    256'(b_bubble_cnt), 256'(0));
`endif
        b_out_ready = 1'b1;
        step();
        check("b.popped", 256'(b_out_valid), 256'(1'b0));
`ifdef ID_EX_STALL_CNT_EN
        check("b.stall_keep", 256'(b_stall_cnt),  256'(5));
        check("b.bubble_pop", 256'(b_bubble_cnt), 256'(0));
        step();
        check("b.bubble1",    256'(b_bubble_cnt), 256'(1));
        b_flush = 1'b1;
        step();
        b_flush = 1'b0;
        check("b.flush_keeps_cnt", 256'(b_stall_cnt), 256'(5));
        check("b.bubble2",         256'(b_bubble_cnt), 256'(2));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each operand and immediate.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of PC.
REQ-003 SHALL have parameter NUM_SRC, default 2, number of source-operand channels (1..4).
REQ-004 SHALL have parameter REG_ADDR_WIDTH, default 5, destination register index width.
REQ-005 SHALL have parameter CTRL_WIDTH, default 16, opaque control-bundle width.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-007 SHALL have ports: in_valid in 1 ID payload valid; in_ready out 1 stage can accept; flush in 1 discard all held entries.
REQ-008 SHALL have ports: in_pc in ADDR_WIDTH; in_rs_data in NUM_SRC*DATA_WIDTH (channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]); in_imm in DATA_WIDTH; in_rd in REG_ADDR_WIDTH; in_ctrl in CTRL_WIDTH.
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1 EX accepts; out_pc, out_rs_data, out_imm, out_rd, out_ctrl out, widths matching the in_ ports.

Function
REQ-010 Input transfer SHALL occur on a rising clk edge when in_valid && in_ready && !flush && !rst; output transfer when out_valid && out_ready.
REQ-011 Storage SHALL be a main register (drives out_*) plus one skid register; states EMPTY (none valid), ONE (main valid), TWO (main and skid valid).
REQ-012 in_ready SHALL equal !skid_valid and SHALL depend on no input combinationally.
REQ-013 EMPTY: input transfer loads main, goes ONE.
REQ-014 ONE: input only -> if out_ready load main (stay ONE) else load skid (go TWO); output only -> EMPTY; both -> main loads new payload, stay ONE; neither -> hold.
REQ-015 TWO: output transfer -> skid moves to main, skid invalid, go ONE; otherwise hold; no input transfer possible.
REQ-016 Latency SHALL be exactly 1 cycle from input transfer to out_valid when EMPTY; sustained throughput 1 payload/cycle when out_ready held high.
REQ-017 Payloads SHALL leave in acceptance order; none duplicated or dropped except by flush/rst.
REQ-018 All out_* payload bits SHALL be registered and hold unchanged while out_valid && !out_ready.
REQ-019 flush SHALL clear main and skid valid on the next edge (go EMPTY) regardless of in_valid/out_ready; a concurrent input is discarded; payload registers MAY retain stale data but out_valid SHALL be 0.
REQ-020 out_* payload SHALL be don't-care to consumers when out_valid=0; verification SHALL check payload only when out_valid=1.

Reset
REQ-021 rst SHALL override flush and all transfers.
REQ-022 On the edge with rst=1: out_valid=0, skid_valid=0, all out_* payload registers=0, state EMPTY; in_ready reads 1 from the following cycle.
REQ-023 rst asserted mid-operation (ONE or TWO) SHALL discard held payloads; no output transfer is reported after that edge.

Configuration
REQ-024 Macro ID_EX_STALL_CNT_EN SHALL, when defined, add output stall_cnt (32 bits) and output bubble_cnt (32 bits).
REQ-025 With ID_EX_STALL_CNT_EN: stall_cnt increments each cycle out_valid && !out_ready; bubble_cnt increments each cycle !out_valid && out_ready; both wrap at 2^32-1 -> 0; both reset to 0 on rst; flush does not clear them.
REQ-026 Without ID_EX_STALL_CNT_EN: ports and counter logic absent; all other behaviour identical.

Verification
REQ-027 Reset: rst=1 two cycles with in_valid=1, in_pc=0x100 -> out_valid=0, payloads 0, in_ready=1 after release; no output.
REQ-028 Streaming: out_ready=1, push pc 0x0,0x4,0x8 back-to-back, rs_data ch0=0xAAAA0000+pc -> out_pc 0x0,0x4,0x8 on consecutive cycles starting 1 cycle after first push, in_ready stays 1.
REQ-029 Backpressure: out_ready=0, push pc 0x10 then 0x14 -> TWO, in_ready=0, out_pc=0x10 stable; out_ready=1 -> 0x10 then 0x14 delivered, in_ready=1 after first pop.
REQ-030 Flush in TWO with in_valid=1 pc 0x20 -> next cycle out_valid=0, in_ready=1; 0x20 never appears.
REQ-031 Flush and rst same cycle from ONE -> reset values; with macro, stall_cnt=0.
REQ-032 NUM_SRC=3, DATA_WIDTH=64: in_rs_data channels 0x1,0x2,0x3 -> same channel order on out_rs_data; with macro, 5 cycles out_valid && !out_ready -> stall_cnt=5.
